sram_arbiter_ctrl: RTL and testbench

//  Synchronous controller and two-port arbiter for the external 16-bit async

---
 rtl/sram_arbiter_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_sram_arbiter_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_ctrl.sv
// Two-port round-robin arbiter and cycle sequencer for a 16-bit asynchronous SRAM.
// Every SRAM strobe comes straight from a flop, and each flop is driven from the next state.
module sram_arbiter_ctrl #(
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WR_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [17:0] p0_addr,
  input  logic [1:0]  p0_be,
  input  logic [15:0] p0_wdata,
  output logic        p0_ack,
  output logic [15:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [17:0] p1_addr,
  input  logic [1:0]  p1_be,
  input  logic [15:0] p1_wdata,
  output logic        p1_ack,
  output logic [15:0] p1_rdata,
  output logic        busy,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_data_o,
  input  logic [15:0] sram_data_i,
  output logic        sram_data_oe,
  output logic        sram_cs_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [2:0] {IDLE, RD, WSET, WPUL, WHLD, DONE} state_t;

  localparam logic [7:0] RD_LAST = 8'(RD_CYCLES - 1);
  localparam logic [7:0] WR_LAST = 8'(WR_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        last_grant_q, last_grant_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic        cs_n_q, cs_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        ub_n_q, ub_n_d;
  logic        lb_n_q, lb_n_d;
  logic        data_oe_q, data_oe_d;
  logic        p0_ack_q, p0_ack_d;
  logic        p1_ack_q, p1_ack_d;
  logic [15:0] p0_rdata_q, p0_rdata_d;
  logic [15:0] p1_rdata_q, p1_rdata_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;

    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          gnt_d        = (p0_req && p1_req) ? ~last_grant_q : p1_req;
          last_grant_d = gnt_d;
          addr_d       = gnt_d ? p1_addr  : p0_addr;
          wdata_d      = gnt_d ? p1_wdata : p0_wdata;
          be_d         = gnt_d ? p1_be    : p0_be;
          cnt_d        = '0;
          state_d      = (gnt_d ? p1_we : p0_we) ? WSET : RD;
        end
      end
      RD: begin
        if (cnt_q == RD_LAST) begin
          if (gnt_q) p1_rdata_d = sram_data_i;
          else       p0_rdata_d = sram_data_i;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WSET: begin
        cnt_d   = '0;
        state_d = WPUL;
      end
      WPUL: begin
        if (cnt_q == WR_LAST) state_d = WHLD;
        else                  cnt_d   = cnt_q + 8'd1;
      end
      WHLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the state being entered, so each one is a clean flop output.
  always_comb begin
    cs_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    ub_n_d    = 1'b1;
    lb_n_d    = 1'b1;
    data_oe_d = 1'b0;
    p0_ack_d  = 1'b0;
    p1_ack_d  = 1'b0;

    case (state_d)
      RD: begin
        cs_n_d = 1'b0;
        oe_n_d = 1'b0;
        ub_n_d = ~be_d[1];
        lb_n_d = ~be_d[0];
      end
      WSET, WPUL, WHLD: begin
        cs_n_d    = 1'b0;
        ub_n_d    = ~be_d[1];
        lb_n_d    = ~be_d[0];
        data_oe_d = 1'b1;
        we_n_d    = (state_d != WPUL);
      end
      DONE: begin
        p0_ack_d = ~gnt_d;
        p1_ack_d = gnt_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      cs_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      ub_n_q       <= 1'b1;
      lb_n_q       <= 1'b1;
      data_oe_q    <= 1'b0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      cs_n_q       <= cs_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      ub_n_q       <= ub_n_d;
      lb_n_q       <= lb_n_d;
      data_oe_q    <= data_oe_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign sram_addr    = addr_q;
  assign sram_data_o  = wdata_q;
  assign sram_data_oe = data_oe_q;
  assign sram_cs_n    = cs_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;
  assign sram_ub_n    = ub_n_q;
  assign sram_lb_n    = lb_n_q;
  assign p0_ack       = p0_ack_q;
  assign p1_ack       = p1_ack_q;
  assign p0_rdata     = p0_rdata_q;
  assign p1_rdata     = p1_rdata_q;

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Bench for sram_arbiter_ctrl: it contains a behavioural SRAM, directed vector tables,
// and a random traffic stream that is checked against a transaction-level shadow memory.
module tb_sram_arbiter_ctrl;
  localparam int RD = 2;
  localparam int WR = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [17:0] p0_addr = '0, p1_addr = '0;
  logic [1:0]  p0_be = '0, p1_be = '0;
  logic [15:0] p0_wdata = '0, p1_wdata = '0;
  logic        p0_ack, p1_ack, busy;
  logic [15:0] p0_rdata, p1_rdata;
  logic [17:0] sram_addr;
  logic [15:0] sram_data_o, sram_data_i;
  logic        sram_data_oe, sram_cs_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  int tests = 0;
  int fails = 0;

  sram_arbiter_ctrl #(.RD_CYCLES(RD), .WR_CYCLES(WR)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_be(p0_be),
    .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_be(p1_be),
    .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .busy(busy), .sram_addr(sram_addr), .sram_data_o(sram_data_o),
    .sram_data_i(sram_data_i), .sram_data_oe(sram_data_oe),
    .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM
  logic [15:0] mem    [0:262143];
  logic [15:0] shadow [0:262143];
  assign sram_data_i = (!sram_cs_n && !sram_oe_n) ? mem[sram_addr] : 16'h0BAD;
  always @(posedge clk) begin
    if (!sram_cs_n && !sram_we_n && sram_data_oe) begin
      if (!sram_ub_n) mem[sram_addr][15:8] <= sram_data_o[15:8];
      if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_data_o[7:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus-level safety rules checked on every cycle
  always @(negedge clk) begin
    chk("oe_and_drive", 32'(!sram_oe_n && sram_data_oe), 0);
    chk("we_without_drive", 32'(!sram_we_n && (!sram_data_oe || sram_cs_n)), 0);
    chk("ack_overlap", 32'(p0_ack && p1_ack), 0);
  end

  bit model_last = 1'b1;

  function automatic int lat(input bit we);
    return we ? WR + 3 : RD + 1;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    logic [15:0] m;
    m = {{8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  // One arbitration round; the expected results come from the shadow memory.
  task automatic do_txn(input bit r0, input bit r1, input bit w0, input bit w1,
                        input logic [17:0] a0, input logic [17:0] a1,
                        input logic [1:0] b0, input logic [1:0] b1,
                        input logic [15:0] d0, input logic [15:0] d1,
                        output int first, output logic [15:0] rd0, output logic [15:0] rd1);
    int cyc, ack0, ack1, f, e0, e1;
    bit pend0, pend1;
    logic [15:0] x0, x1;
    @(posedge clk); #1;
    chk("idle_ack0", 32'(p0_ack), 0);
    chk("idle_ack1", 32'(p1_ack), 0);
    chk("idle_busy", 32'(busy), 0);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_be = b0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_be = b1; p1_wdata = d1;
    pend0 = r0; pend1 = r1; cyc = 0; ack0 = -1; ack1 = -1; first = -1;
    rd0 = '0; rd1 = '0;
    while ((pend0 || pend1) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) chk("busy_after_grant", 32'(busy), 1);
      chk("spurious_ack0", 32'(p0_ack && !pend0), 0);
      chk("spurious_ack1", 32'(p1_ack && !pend1), 0);
      if (p0_ack && pend0) begin
        ack0 = cyc; rd0 = p0_rdata; pend0 = 0; p0_req = 0;
        if (first < 0) first = 0;
      end
      if (p1_ack && pend1) begin
        ack1 = cyc; rd1 = p1_rdata; pend1 = 0; p1_req = 0;
        if (first < 0) first = 1;
      end
    end
    chk("timeout", 32'(pend0 || pend1), 0);
    p0_req = 0; p1_req = 0;

    f  = (r0 && r1) ? int'(!model_last) : int'(r1);
    e0 = -1; e1 = -1; x0 = '0; x1 = '0;
    for (int k = 0; k < 2; k++) begin
      int p;
      int prev;
      p = (k == 0) ? f : 1 - f;
      if ((p == 0 && !r0) || (p == 1 && !r1)) continue;
      prev = (k == 0) ? 0 : ((f == 0) ? e0 : e1) + 1;
      if (p == 0) begin
        e0 = prev + lat(w0);
        if (w0) shadow[a0] = merge(shadow[a0], d0, b0); else x0 = shadow[a0];
      end else begin
        e1 = prev + lat(w1);
        if (w1) shadow[a1] = merge(shadow[a1], d1, b1); else x1 = shadow[a1];
      end
      model_last = p[0];
    end
    chk("first_grant", 32'(first), 32'(f));
    chk("ack0_cycle", 32'(ack0), 32'(e0));
    chk("ack1_cycle", 32'(ack1), 32'(e1));
    if (r0 && !w0) chk("rdata0", 32'(rd0), 32'(x0));
    if (r1 && !w1) chk("rdata1", 32'(rd1), 32'(x1));
  endtask

  typedef struct {
    bit r0, r1, w0, w1;
    logic [17:0] a0, a1;
    logic [1:0]  b0, b1;
    logic [15:0] d0, d1;
    int          exp_first;
    logic [15:0] exp_rd0, exp_rd1;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int first;
    logic [15:0] rd0, rd1;
    int wait_cyc;

    for (int i = 0; i < 262144; i++) begin mem[i] = '0; shadow[i] = '0; end
    mem[18'h00001] = 16'hBEEF; shadow[18'h00001] = 16'hBEEF;
    mem[18'h00010] = 16'h1234; shadow[18'h00010] = 16'h1234;
    mem[18'h00020] = 16'hCAFE; shadow[18'h00020] = 16'hCAFE;

    //            r0 r1 w0 w1  a0        a1        b0     b1     d0        d1       first rd0      rd1
    vecs[0] = '{1, 0, 0, 0, 18'h00001, 18'h0,    2'b11, 2'b00, 16'h0,    16'h0,    0, 16'hBEEF, 16'h0};
    vecs[1] = '{0, 1, 0, 1, 18'h0,    18'h00010, 2'b00, 2'b10, 16'h0,    16'hA5C3, 1, 16'h0,    16'h0};
    vecs[2] = '{1, 0, 0, 0, 18'h00010, 18'h0,    2'b11, 2'b00, 16'h0,    16'h0,    0, 16'hA534, 16'h0};
    vecs[3] = '{1, 1, 1, 0, 18'h00020, 18'h00020, 2'b01, 2'b11, 16'h1111, 16'h0,    1, 16'h0,    16'hCAFE};
    vecs[4] = '{1, 1, 0, 1, 18'h00020, 18'h00020, 2'b11, 2'b00, 16'h0,    16'hFFFF, 1, 16'hCA11, 16'h0};
    vecs[5] = '{0, 1, 0, 0, 18'h0,    18'h00020, 2'b00, 2'b00, 16'h0,    16'h0,    1, 16'h0,    16'hCA11};
    vecs[6] = '{1, 1, 0, 0, 18'h00001, 18'h00010, 2'b11, 2'b11, 16'h0,    16'h0,    0, 16'hBEEF, 16'hA534};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(sram_cs_n), 1);
    chk("rst_oe_n", 32'(sram_oe_n), 1);
    chk("rst_we_n", 32'(sram_we_n), 1);
    chk("rst_ub_lb", 32'({sram_ub_n, sram_lb_n}), 3);
    chk("rst_data_oe", 32'(sram_data_oe), 0);
    chk("rst_acks", 32'({p0_ack, p1_ack}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_rdata", 32'({p0_rdata, p1_rdata}), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_txn(vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1, vecs[i].a0, vecs[i].a1,
             vecs[i].b0, vecs[i].b1, vecs[i].d0, vecs[i].d1, first, rd0, rd1);
      chk($sformatf("vec%0d_first", i), 32'(first), 32'(vecs[i].exp_first));
      if (vecs[i].r0 && !vecs[i].w0) chk($sformatf("vec%0d_rd0", i), 32'(rd0), 32'(vecs[i].exp_rd0));
      if (vecs[i].r1 && !vecs[i].w1) chk($sformatf("vec%0d_rd1", i), 32'(rd1), 32'(vecs[i].exp_rd1));
    end

    // Reset during the write pulse abandons the transaction
    @(posedge clk); #1;
    p0_req = 1; p0_we = 1; p0_addr = 18'h3FFFF; p0_be = 2'b11; p0_wdata = 16'h5A5A;
    wait_cyc = 0;
    do begin
      @(posedge clk); #1;
      wait_cyc++;
    end while (sram_we_n && wait_cyc < 10);
    chk("t6_reach_wpul", 32'(sram_we_n), 0);
    rst_n = 0; p0_req = 0;
    @(posedge clk); #1;
    chk("t6_we_n", 32'(sram_we_n), 1);
    chk("t6_data_oe", 32'(sram_data_oe), 0);
    chk("t6_cs_n", 32'(sram_cs_n), 1);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ack", 32'(p0_ack), 0);
    @(posedge clk); #1;
    chk("t6_ack_late", 32'(p0_ack), 0);
    rst_n = 1;
    model_last = 1'b1;

    // Simultaneous requests after reset alternate p0,p1,p0,p1
    for (int r = 0; r < 2; r++) begin
      do_txn(1, 1, 0, 0, 18'h00001, 18'h00010, 2'b11, 2'b11, 16'h0, 16'h0, first, rd0, rd1);
      chk($sformatf("t4_round%0d_first", r), 32'(first), 0);
    end

    // Write then read the same address back to back
    do_txn(1, 1, 1, 0, 18'h00040, 18'h00040, 2'b11, 2'b11, 16'h7E57, 16'h0, first, rd0, rd1);
    do_txn(1, 1, 0, 1, 18'h00040, 18'h00040, 2'b11, 2'b11, 16'h0, 16'h9999, first, rd0, rd1);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      do_txn(mode != 1, mode != 0, 1'($urandom), 1'($urandom),
             18'h00100 + 18'($urandom_range(0, 15)), 18'h00100 + 18'($urandom_range(0, 15)),
             2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), first, rd0, rd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
